// File: rtl/bcp_core.sv
// bcp_core -- Boolean constraint propagation engine for a small SAT solver.
//
// Walks an inclusive range of clauses held in an external clause memory.
// Each clause holds up to three literals. Every literal is checked against
// the current variable assignment. The engine then does one of three things:
//   - it flags a conflict on a clause where every literal is false,
//   - it pushes a forced implication for a unit clause,
//   - or it moves on to the next clause.
//
// Ports:
//   clock, reset (async, active-low)      clocking and reset
//   start, start_clause, end_clause       run request and inclusive range
//   reset_bcp                             synchronous abort
//   clause_rd, clause_addr, clause_data   clause memory port (1-cycle read latency)
//   vs_var0..2 / vs_val0..2 / vs_unassigned0..2
//                                         same-cycle variable-state lookup
//   push_imply, var_in_imply, val_in_imply, type_in_imply, full_imply
//                                         implication queue push port
//   bcp_busy, conflict, bcp_clause_idx    status

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module bcp_core (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic [`MAX_CLAUSES_BITS-1:0]      start_clause,
   input  logic [`MAX_CLAUSES_BITS-1:0]      end_clause,
   input  logic                              reset_bcp,
   output logic                              clause_rd,
   output logic [`MAX_CLAUSES_BITS-1:0]      clause_addr,
   input  logic [3*(`MAX_VARS_BITS+2)-1:0]   clause_data,
   output logic [`MAX_VARS_BITS-1:0]         vs_var0,
   output logic [`MAX_VARS_BITS-1:0]         vs_var1,
   output logic [`MAX_VARS_BITS-1:0]         vs_var2,
   input  logic                              vs_val0,
   input  logic                              vs_val1,
   input  logic                              vs_val2,
   input  logic                              vs_unassigned0,
   input  logic                              vs_unassigned1,
   input  logic                              vs_unassigned2,
   output logic                              push_imply,
   output logic [`MAX_VARS_BITS-1:0]         var_in_imply,
   output logic                              val_in_imply,
   output logic                              type_in_imply,
   input  logic                              full_imply,
   output logic                              bcp_busy,
   output logic                              conflict,
   output logic [`MAX_CLAUSES_BITS-1:0]      bcp_clause_idx
);

   localparam int VB = `MAX_VARS_BITS;
   localparam int CB = `MAX_CLAUSES_BITS;
   localparam int LW = VB + 2;

   typedef enum logic [1:0] {IDLE, FETCH, EVAL} state_t;

   state_t            state, next_state;
   logic [CB-1:0]     idx, end_idx;
   logic [3*LW-1:0]   held_data;
   logic              first_eval;
   logic              busy_q, conflict_q;

   logic [3*LW-1:0]   eval_data;
   logic [VB-1:0]     lit_var [3];
   logic [2:0]        lit_valid, lit_pol, lit_true, lit_open;
   logic [2:0]        vs_val_v, vs_un_v;
   logic              satisfied, zero_open, one_open;
   logic [VB-1:0]     open_var;
   logic              open_pol;

   logic              accept, advance, set_conflict, clear_conflict;

   // The read data arrives during the first EVAL cycle. Use it directly there
   // so a clause takes two cycles. Replay the captured copy while a push is
   // being retried against a full queue.
   assign eval_data = first_eval ? clause_data : held_data;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         lit_var[i]   = eval_data[i*LW +: VB];
         lit_pol[i]   = eval_data[i*LW + VB];
         lit_valid[i] = eval_data[i*LW + VB + 1];
      end
   end

   assign vs_var0  = lit_var[0];
   assign vs_var1  = lit_var[1];
   assign vs_var2  = lit_var[2];
   assign vs_val_v = {vs_val2, vs_val1, vs_val0};
   assign vs_un_v  = {vs_unassigned2, vs_unassigned1, vs_unassigned0};

   assign lit_true  = lit_valid & ~vs_un_v & ~(vs_val_v ^ lit_pol);
   assign lit_open  = lit_valid & vs_un_v;
   assign satisfied = |lit_true;
   assign zero_open = ~|lit_open;
   assign one_open  = (lit_open == 3'b001) || (lit_open == 3'b010) || (lit_open == 3'b100);

   always_comb begin
      open_var = lit_var[2];
      open_pol = lit_pol[2];
      if (lit_open[0]) begin
         open_var = lit_var[0];
         open_pol = lit_pol[0];
      end else if (lit_open[1]) begin
         open_var = lit_var[1];
         open_pol = lit_pol[1];
      end
   end

   // Next-state and strobe logic. reset_bcp overrides everything, including
   // the read and push strobes of the current cycle.
   always_comb begin
      next_state     = state;
      clause_rd      = 1'b0;
      push_imply     = 1'b0;
      accept         = 1'b0;
      advance        = 1'b0;
      set_conflict   = 1'b0;
      clear_conflict = 1'b0;
      if (reset_bcp) begin
         next_state     = IDLE;
         clear_conflict = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  clear_conflict = 1'b1;
                  if (start_clause <= end_clause) begin
                     accept     = 1'b1;
                     next_state = FETCH;
                  end
               end
            end
            FETCH: begin
               clause_rd  = 1'b1;
               next_state = EVAL;
            end
            EVAL: begin
               if (!satisfied && zero_open) begin
                  set_conflict = 1'b1;
                  next_state   = IDLE;
               end else if (!satisfied && one_open && full_imply) begin
                  next_state = EVAL;
               end else begin
                  push_imply = !satisfied && one_open;
                  if (idx == end_idx) begin
                     next_state = IDLE;
                  end else begin
                     advance    = 1'b1;
                     next_state = FETCH;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   assign clause_addr    = idx;
   assign var_in_imply   = push_imply ? open_var : '0;
   assign val_in_imply   = push_imply & open_pol;
   assign type_in_imply  = push_imply;
   assign bcp_busy       = busy_q;
   assign conflict       = conflict_q;
   assign bcp_clause_idx = idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         end_idx    <= '0;
         held_data  <= '0;
         first_eval <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state      <= next_state;
         busy_q     <= (next_state != IDLE);
         first_eval <= (state == FETCH) && (next_state == EVAL);
         if (first_eval)
            held_data <= clause_data;
         if (accept) begin
            idx     <= start_clause;
            end_idx <= end_clause;
         end else if (advance) begin
            idx <= idx + 1'b1;
         end
         if (clear_conflict)
            conflict_q <= 1'b0;
         else if (set_conflict)
            conflict_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bcp_core.sv
// tb_bcp_core -- scoreboard bench for bcp_core. A behavioural model of the
// clause walk queues the expected reads and pushes. A monitor pops them as
// the DUT strobes clause_rd / push_imply.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module tb_bcp_core;

   localparam int VB = `MAX_VARS_BITS;
   localparam int CB = `MAX_CLAUSES_BITS;
   localparam int LW = VB + 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [CB-1:0]     start_clause, end_clause;
   logic              reset_bcp;
   logic              clause_rd;
   logic [CB-1:0]     clause_addr;
   logic [3*LW-1:0]   clause_data;
   logic [VB-1:0]     vs_var0, vs_var1, vs_var2;
   logic              vs_val0, vs_val1, vs_val2;
   logic              vs_unassigned0, vs_unassigned1, vs_unassigned2;
   logic              push_imply;
   logic [VB-1:0]     var_in_imply;
   logic              val_in_imply, type_in_imply;
   logic              full_imply;
   logic              bcp_busy, conflict;
   logic [CB-1:0]     bcp_clause_idx;

   logic [3*LW-1:0]   mem [256];
   logic              var_val [256];
   logic              var_un  [256];

   int                exp_read_q [$];
   int                exp_push_q [$];
   int                exp_conflict;
   int                exp_idx;
   int                errors = 0;
   int                checks = 0;
   int                bc;

   bcp_core dut (
      .clock(clock), .reset(reset), .start(start),
      .start_clause(start_clause), .end_clause(end_clause),
      .reset_bcp(reset_bcp),
      .clause_rd(clause_rd), .clause_addr(clause_addr), .clause_data(clause_data),
      .vs_var0(vs_var0), .vs_var1(vs_var1), .vs_var2(vs_var2),
      .vs_val0(vs_val0), .vs_val1(vs_val1), .vs_val2(vs_val2),
      .vs_unassigned0(vs_unassigned0), .vs_unassigned1(vs_unassigned1),
      .vs_unassigned2(vs_unassigned2),
      .push_imply(push_imply), .var_in_imply(var_in_imply),
      .val_in_imply(val_in_imply), .type_in_imply(type_in_imply),
      .full_imply(full_imply),
      .bcp_busy(bcp_busy), .conflict(conflict), .bcp_clause_idx(bcp_clause_idx)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      if (clause_rd) clause_data <= mem[clause_addr];

   assign vs_val0        = var_val[vs_var0];
   assign vs_val1        = var_val[vs_var1];
   assign vs_val2        = var_val[vs_var2];
   assign vs_unassigned0 = var_un[vs_var0];
   assign vs_unassigned1 = var_un[vs_var1];
   assign vs_unassigned2 = var_un[vs_var2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [LW-1:0] lit(input logic v, input logic p, input int var_n);
      logic [VB-1:0] vn;
      vn = var_n[VB-1:0];
      return {v, p, vn};
   endfunction

   // Reference walk of the clause range.
   task automatic modelRun(input int s, input int e);
      logic [3*LW-1:0] cl;
      logic [LW-1:0]   l;
      int              nopen, ov, op;
      logic            sat;
      exp_conflict = 0;
      exp_idx      = e;
      for (int i = s; i <= e; i++) begin
         exp_read_q.push_back(i);
         cl    = mem[i];
         sat   = 1'b0;
         nopen = 0;
         ov    = 0;
         op    = 0;
         for (int k = 0; k < 3; k++) begin
            l = cl[k*LW +: LW];
            if (l[LW-1]) begin
               if (var_un[l[VB-1:0]]) begin
                  nopen++;
                  ov = int'(l[VB-1:0]);
                  op = int'(l[VB]);
               end else if (var_val[l[VB-1:0]] == l[VB]) begin
                  sat = 1'b1;
               end
            end
         end
         if (!sat) begin
            if (nopen == 0) begin
               exp_conflict = 1;
               exp_idx      = i;
               break;
            end
            if (nopen == 1) exp_push_q.push_back(ov * 2 + op);
         end
      end
   endtask

   task automatic applyStimulus(input int s, input int e, output int busy_cycles);
      @(posedge clock) #1;
      start        = 1'b1;
      start_clause = s[CB-1:0];
      end_clause   = e[CB-1:0];
      @(posedge clock) #1;
      start = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (bcp_busy) busy_cycles++;
         else break;
      end
   endtask

   // Monitor: every read and push must match the head of its queue.
   always @(negedge clock) begin
      int ev;
      if (reset) begin
         if (clause_rd) begin
            if (exp_read_q.size() == 0) checkOutput("extra_rd", 1, 0);
            else begin
               ev = exp_read_q.pop_front();
               checkOutput("rd_addr", 32'(clause_addr), ev);
            end
         end
         if (push_imply) begin
            if (full_imply) checkOutput("push_while_full", 1, 0);
            if (exp_push_q.size() == 0) checkOutput("extra_push", 1, 0);
            else begin
               ev = exp_push_q.pop_front();
               checkOutput("push_var", 32'(var_in_imply), ev / 2);
               checkOutput("push_val", 32'(val_in_imply), ev % 2);
               checkOutput("push_type", 32'(type_in_imply), 1);
            end
         end
      end
   end

   task automatic checkDrained(input string tag);
      checkOutput({tag, "_reads_left"}, exp_read_q.size(), 0);
      checkOutput({tag, "_pushes_left"}, exp_push_q.size(), 0);
      exp_read_q.delete();
      exp_push_q.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      start_clause = '0;
      end_clause   = '0;
      reset_bcp    = 1'b0;
      full_imply   = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         var_val[i] = 1'b0;
         var_un[i]  = 1'b1;
      end
      // x1 true, x2 false, x3 false, x7 unassigned
      var_val[1] = 1'b1; var_un[1] = 1'b0;
      var_val[2] = 1'b0; var_un[2] = 1'b0;
      var_val[3] = 1'b0; var_un[3] = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = {lit(0,0,0), lit(0,0,0), lit(1,1,1)};
      mem[4] = {lit(1,1,3), lit(1,0,1), lit(1,1,2)};
      mem[5] = {lit(0,0,0), lit(1,0,7), lit(1,1,3)};

      #1;
      checkOutput("rst_busy", 32'(bcp_busy), 0);
      checkOutput("rst_conflict", 32'(conflict), 0);
      checkOutput("rst_idx", 32'(bcp_clause_idx), 0);
      checkOutput("rst_rd", 32'(clause_rd), 0);
      checkOutput("rst_push", 32'(push_imply), 0);
      #10 reset = 1'b1;

      // All clauses satisfied
      modelRun(0, 2);
      applyStimulus(0, 2, bc);
      checkOutput("sat_busy_cycles", bc, 6);
      checkOutput("sat_conflict", 32'(conflict), 0);
      checkOutput("sat_idx_hold", 32'(bcp_clause_idx), 2);
      checkDrained("sat");

      // Unit clause implies x7=0
      modelRun(5, 5);
      applyStimulus(5, 5, bc);
      checkOutput("unit_busy_cycles", bc, 2);
      checkOutput("unit_conflict", 32'(conflict), 0);
      checkDrained("unit");

      // Same with the implication queue full for the first three EVAL cycles
      full_imply = 1'b1;
      modelRun(5, 5);
      fork
         applyStimulus(5, 5, bc);
         begin
            repeat (6) @(posedge clock);
            #1 full_imply = 1'b0;
         end
      join
      checkOutput("full_busy_cycles", bc, 5);
      checkDrained("full");

      // Conflict at clause 4 stops the walk
      modelRun(0, 10);
      applyStimulus(0, 10, bc);
      checkOutput("cfl_busy_cycles", bc, 10);
      checkOutput("cfl_conflict", 32'(conflict), exp_conflict);
      checkOutput("cfl_idx", 32'(bcp_clause_idx), exp_idx);
      repeat (3) @(negedge clock);
      checkOutput("cfl_conflict_hold", 32'(conflict), 1);
      checkDrained("cfl");

      // reset_bcp in IDLE clears the conflict flag
      @(posedge clock) #1 reset_bcp = 1'b1;
      @(posedge clock) #1 reset_bcp = 1'b0;
      checkOutput("rbcp_idle_conflict", 32'(conflict), 0);

      // reset_bcp during the fetch of clause 6 aborts without a read
      @(posedge clock) #1;
      start = 1'b1; start_clause = 6; end_clause = 12;
      @(posedge clock) #1;
      start = 1'b0; reset_bcp = 1'b1;
      @(negedge clock);
      checkOutput("abort_busy_before", 32'(bcp_busy), 1);
      checkOutput("abort_idx", 32'(bcp_clause_idx), 6);
      checkOutput("abort_rd_gated", 32'(clause_rd), 0);
      @(posedge clock) #1 reset_bcp = 1'b0;
      @(negedge clock);
      checkOutput("abort_busy_after", 32'(bcp_busy), 0);
      checkOutput("abort_conflict", 32'(conflict), 0);
      repeat (4) @(negedge clock);
      checkDrained("abort");

      // Reversed range is ignored
      applyStimulus(3, 1, bc);
      checkOutput("rev_busy_cycles", bc, 0);
      checkDrained("rev");

      // Async reset in the middle of an EVAL with a push on the port
      exp_read_q.push_back(5);
      @(posedge clock) #1;
      start = 1'b1; start_clause = 5; end_clause = 5;
      @(posedge clock) #1 start = 1'b0;
      @(posedge clock) #1;
      checkOutput("arst_push_pending", 32'(push_imply), 1);
      #1 reset = 1'b0;
      #1;
      checkOutput("arst_push", 32'(push_imply), 0);
      checkOutput("arst_busy", 32'(bcp_busy), 0);
      checkOutput("arst_conflict", 32'(conflict), 0);
      checkOutput("arst_idx", 32'(bcp_clause_idx), 0);
      checkOutput("arst_addr", 32'(clause_addr), 0);
      checkOutput("arst_rd", 32'(clause_rd), 0);
      checkOutput("arst_var", 32'(var_in_imply), 0);
      checkOutput("arst_val", 32'(val_in_imply), 0);
      checkOutput("arst_type", 32'(type_in_imply), 0);
      #20 reset = 1'b1;
      repeat (3) @(negedge clock);
      checkDrained("arst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcp_core.md
BCP_CORE -- requirements
Module: bcp_core

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset (reset=0 asserts immediately; deassertion synchronous to clock).
REQ-003 SHALL have port: start  in  1  one-cycle request to run BCP over the clause range.
REQ-004 SHALL have ports: start_clause, end_clause  in  `MAX_CLAUSES_BITS each  inclusive clause range, sampled only with start.
REQ-005 SHALL have port: reset_bcp  in  1  synchronous abort from control.
REQ-006 SHALL have ports: clause_rd  out  1, clause_addr  out  `MAX_CLAUSES_BITS  clause memory read request/address.
REQ-007 SHALL have port: clause_data  in  3*(`MAX_VARS_BITS+2), valid exactly 1 cycle after clause_rd; three literals {valid, polarity, var}, literal 0 in the LSBs.
REQ-008 SHALL have ports: vs_var0..2  out  `MAX_VARS_BITS; vs_val0..2, vs_unassigned0..2  in  1; combinational same-cycle var-state lookup.
REQ-009 SHALL have ports: push_imply  out  1, var_in_imply  out  `MAX_VARS_BITS, val_in_imply  out  1, type_in_imply  out  1, full_imply  in  1.
REQ-010 SHALL have ports: bcp_busy  out  1, conflict  out  1, bcp_clause_idx  out  `MAX_CLAUSES_BITS.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, EVAL; bcp_busy = (state != IDLE), registered.
REQ-012 IDLE: on start=1 and reset_bcp=0 with start_clause <= end_clause, SHALL latch idx=start_clause, end=end_clause, clear conflict, go FETCH.
REQ-013 IDLE: on start with start_clause > end_clause SHALL stay IDLE, clear conflict, issue no read, leave bcp_busy=0.
REQ-014 FETCH: SHALL assert clause_rd=1, clause_addr=idx for one cycle, then go EVAL.
REQ-015 EVAL: SHALL register clause_data on entry and hold it until leaving EVAL.
REQ-016 Literal true = valid & !vs_unassigned & (vs_val == polarity); literal open = valid & vs_unassigned.
REQ-017 Clause with any true literal: satisfied, no action.
REQ-018 Not satisfied, zero open literals (including no valid literals): SHALL set conflict=1, bcp_clause_idx=idx, go IDLE; no push.
REQ-019 Not satisfied, exactly one open literal: SHALL push {var, val=polarity, type=1 (forced)} with push_imply=1 for one cycle; if full_imply=1, SHALL stay in EVAL without pushing and retry each cycle.
REQ-020 Not satisfied, two or more open literals: no action.
REQ-021 After a non-conflict EVAL completes: idx==end -> IDLE; else idx=idx+1, go FETCH (2 cycles per clause, no stall).
REQ-022 bcp_clause_idx SHALL equal idx while busy and hold its last value in IDLE.
REQ-023 conflict SHALL hold until the next accepted start or reset_bcp.
REQ-024 start while busy SHALL be ignored.
REQ-025 reset_bcp SHALL have priority over start and every FSM action: next state IDLE, conflict=0, and no clause_rd or push_imply in the reset_bcp cycle.
REQ-026 Duplicate implications of the same variable are NOT filtered; consumer handles them.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, bcp_busy=0, conflict=0, bcp_clause_idx=0, clause_rd=0, clause_addr=0, push_imply=0, var_in_imply=0, val_in_imply=0, type_in_imply=0; mid-run reset SHALL discard the run.

Verification
REQ-028 start, range 0..2, all clauses satisfied -> clause_rd at addr 0,1,2 on alternate cycles, bcp_busy high for 6 cycles, no push, conflict=0.
REQ-029 clause 5 = {x3 pos, x7 neg}, x3 false, x7 unassigned -> push_imply once with var=7, val=0, type=1.
REQ-030 Same as REQ-029 with full_imply=1 for 3 cycles -> FSM holds EVAL, push occurs on the cycle full_imply drops, exactly one push.
REQ-031 range 0..10, clause 4 all literals false -> conflict=1, bcp_clause_idx=4, bcp_busy falls, no fetch of clause 5.
REQ-032 reset_bcp asserted mid-run at idx 6 -> IDLE next cycle, conflict=0, no further clause_rd; start with range 3..1 -> bcp_busy stays 0.
REQ-033 reset=0 asserted during EVAL with push pending -> all outputs at reset values without waiting for a clock edge.
